// File: rtl/vga_timing_pkg.sv
// ----------------------------------------------------------------------------
// vga_timing_pkg
// Shared constants for the VGA raster timing generator: phase encoding of one
// axis, counter width, default 640x480@60 timing and a parameter sanity helper.
// ----------------------------------------------------------------------------
package vga_timing_pkg;

   localparam int CNT_W = 12;

   localparam logic [1:0] PH_ACTIVE = 2'd0;
   localparam logic [1:0] PH_FP     = 2'd1;
   localparam logic [1:0] PH_SYNC   = 2'd2;
   localparam logic [1:0] PH_BP     = 2'd3;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   // An axis is usable when every phase is at least one count long and the
   // whole period still fits the 12-bit counter.
   function automatic bit timingFits(int active, int fp, int sync, int bp);
      return (active >= 1) && (fp >= 1) && (sync >= 1) && (bp >= 1) &&
             ((active + fp + sync + bp) <= 4095);
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// ----------------------------------------------------------------------------
// vga_axis_counter
// One raster axis: a counter running 0..TOTAL-1 with a decode of which phase
// (ACTIVE, FP, SYNC, BP) the current count lies in.
// Ports:
//   i_clk    clock
//   i_rst    synchronous active-high reset, count -> 0
//   i_clr    synchronous clear, count -> 0 (raster stopped)
//   i_inc    advance by one count
//   o_count  current count
//   o_phase  phase of the current count (PH_* encoding)
//   o_wrap   count is at its last value (TOTAL-1)
// ----------------------------------------------------------------------------
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int ACTIVE = DEF_H_ACTIVE,
   parameter int FP     = DEF_H_FP,
   parameter int SYNC   = DEF_H_SYNC,
   parameter int BP     = DEF_H_BP
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_count,
   output logic [1:0]       o_phase,
   output logic             o_wrap
);

   localparam logic [CNT_W-1:0] FP_START   = CNT_W'(ACTIVE);
   localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FP);
   localparam logic [CNT_W-1:0] BP_START   = CNT_W'(ACTIVE + FP + SYNC);
   localparam logic [CNT_W-1:0] LAST       = CNT_W'(ACTIVE + FP + SYNC + BP - 1);

   logic [CNT_W-1:0] r_count;

   // Counter: reset and clear both force zero; otherwise step on i_inc and
   // roll over from LAST back to zero.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_count <= '0;
      end else if (i_inc) begin
         if (r_count == LAST) begin
            r_count <= '0;
         end else begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   // Phase decode: the phases are contiguous ranges starting at 0, so a chain
   // of less-than compares against the range starts is enough.
   always_comb begin
      o_phase = PH_BP;
      if (r_count < FP_START) begin
         o_phase = PH_ACTIVE;
      end else if (r_count < SYNC_START) begin
         o_phase = PH_FP;
      end else if (r_count < BP_START) begin
         o_phase = PH_SYNC;
      end
   end

   assign o_count = r_count;
   assign o_wrap  = (r_count == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
// VGA raster timing: sync pulses, data enable, pixel coordinates and
// line/frame strobes, built from a horizontal and a vertical axis counter.
// Ports:
//   i_clk          clock
//   i_rst          synchronous active-high reset
//   i_en           run enable; 0 stops the raster and clears the counters
//   i_pix_ce       pixel-rate clock enable
//   o_hsync        horizontal sync, HPOL level during the H SYNC phase
//   o_vsync        vertical sync, VPOL level during the V SYNC phase
//   o_de           data enable (H ACTIVE and V ACTIVE)
//   o_x, o_y       pixel coordinates
//   o_line_start   one-clk strobe at x==0 on a pixel tick
//   o_frame_start  one-clk strobe at x==0, y==0 on a pixel tick
// Configuration macro: VGA_TG_OUTREG_EN adds one register stage on every
// output (1 clk extra latency, glitch-free pads); undefined = combinational.
// ----------------------------------------------------------------------------
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit HPOL     = 1'b0,
   parameter bit VPOL     = 1'b0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_pix_ce,
   output logic             o_hsync,
   output logic             o_vsync,
   output logic             o_de,
   output logic [CNT_W-1:0] o_x,
   output logic [CNT_W-1:0] o_y,
   output logic             o_line_start,
   output logic             o_frame_start
);

   // Refuse to build a raster whose phases are empty or whose period does not
   // fit the 12-bit coordinate counters.
   if (!timingFits(H_ACTIVE, H_FP, H_SYNC, H_BP) ||
       !timingFits(V_ACTIVE, V_FP, V_SYNC, V_BP)) begin : g_badTiming
      $error("vga_timing_gen: timing parameters must be >= 1 with totals <= 4095");
   end

   logic             r_running;
   logic             w_advance;
   logic             w_clr;
   logic             w_hWrap;
   logic             w_vInc;
   logic             w_unusedVWrap;
   logic [CNT_W-1:0] w_hCount;
   logic [CNT_W-1:0] w_vCount;
   logic [1:0]       w_hPhase;
   logic [1:0]       w_vPhase;
   logic             w_hsync;
   logic             w_vsync;
   logic             w_de;
   logic [CNT_W-1:0] w_x;
   logic [CNT_W-1:0] w_y;
   logic             w_lineStart;
   logic             w_frameStart;

   // Run flag: any edge with reset or en low stops the raster; the first edge
   // with both clear starts it, and the counters are still at (0,0) then.
   always_ff @(posedge i_clk) begin
      if (i_rst || !i_en) begin
         r_running <= 1'b0;
      end else begin
         r_running <= 1'b1;
      end
   end

   // Counters are cleared on the very edge en drops, so they already read
   // (0,0) when a new run starts. The vertical axis steps only on the
   // horizontal wrap tick, which keeps vsync line-aligned.
   assign w_advance = r_running & i_pix_ce;
   assign w_clr     = ~i_en | ~r_running;
   assign w_vInc    = w_hWrap & w_advance;

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP)
   ) u_hAxis (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clr   (w_clr),
      .i_inc   (w_advance),
      .o_count (w_hCount),
      .o_phase (w_hPhase),
      .o_wrap  (w_hWrap)
   );

   // The vertical wrap is implied by the horizontal wrap plus y==last and is
   // not needed by anything here.
   vga_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP)
   ) u_vAxis (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clr   (w_clr),
      .i_inc   (w_vInc),
      .o_count (w_vCount),
      .o_phase (w_vPhase),
      .o_wrap  (w_unusedVWrap)
   );

   // Output decode: everything sits at its inactive level unless the raster
   // is running. Strobes are qualified with the pixel enable so they stay one
   // clk wide even when x lingers at 0 for several clks.
   always_comb begin
      w_hsync      = ~HPOL;
      w_vsync      = ~VPOL;
      w_de         = 1'b0;
      w_x          = '0;
      w_y          = '0;
      w_lineStart  = 1'b0;
      w_frameStart = 1'b0;
      if (r_running) begin
         w_hsync      = (w_hPhase == PH_SYNC) ? HPOL : ~HPOL;
         w_vsync      = (w_vPhase == PH_SYNC) ? VPOL : ~VPOL;
         w_de         = (w_hPhase == PH_ACTIVE) && (w_vPhase == PH_ACTIVE);
         w_x          = w_hCount;
         w_y          = w_vCount;
         w_lineStart  = i_pix_ce && (w_hCount == '0);
         w_frameStart = i_pix_ce && (w_hCount == '0) && (w_vCount == '0);
      end
   end

`ifdef VGA_TG_OUTREG_EN
   logic             r_hsync;
   logic             r_vsync;
   logic             r_de;
   logic [CNT_W-1:0] r_x;
   logic [CNT_W-1:0] r_y;
   logic             r_lineStart;
   logic             r_frameStart;

   // Pad register stage: a plain one-clk copy of the decode, reset to the
   // inactive levels.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_hsync      <= ~HPOL;
         r_vsync      <= ~VPOL;
         r_de         <= 1'b0;
         r_x          <= '0;
         r_y          <= '0;
         r_lineStart  <= 1'b0;
         r_frameStart <= 1'b0;
      end else begin
         r_hsync      <= w_hsync;
         r_vsync      <= w_vsync;
         r_de         <= w_de;
         r_x          <= w_x;
         r_y          <= w_y;
         r_lineStart  <= w_lineStart;
         r_frameStart <= w_frameStart;
      end
   end

   assign o_hsync       = r_hsync;
   assign o_vsync       = r_vsync;
   assign o_de          = r_de;
   assign o_x           = r_x;
   assign o_y           = r_y;
   assign o_line_start  = r_lineStart;
   assign o_frame_start = r_frameStart;
`else
   assign o_hsync       = w_hsync;
   assign o_vsync       = w_vsync;
   assign o_de          = w_de;
   assign o_x           = w_x;
   assign o_y           = w_y;
   assign o_line_start  = w_lineStart;
   assign o_frame_start = w_frameStart;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_gen
// Drives a default 640x480 timing generator and a tiny-raster one (HPOL=1,
// VPOL=0) from shared random inputs and compares both every cycle against a
// model that derives coordinates from the number of pixel ticks since the run
// began. Honours VGA_TG_OUTREG_EN by delaying the expectations one clk.
// ----------------------------------------------------------------------------
module tb_vga_timing_gen;

   typedef struct {
      bit        hsync;
      bit        vsync;
      bit        de;
      bit [11:0] x;
      bit [11:0] y;
      bit        ls;
      bit        fs;
   } outs_t;

   logic clk = 1'b0;
   logic rst;
   logic en;
   logic pixCe;

   logic        dHs, dVs, dDe, dLs, dFs;
   logic [11:0] dX, dY;
   logic        sHs, sVs, sDe, sLs, sFs;
   logic [11:0] sX, sY;

   int checkCount = 0;
   int errorCount = 0;
   bit compareEnable = 1'b0;

   int modelTicks = 0;
   bit modelRun = 1'b0;
   bit rstAtEdge = 1'b0;
   outs_t prevD;
   outs_t prevS;

   always #5 clk = ~clk;

   vga_timing_gen u_dutDefault (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_en          (en),
      .i_pix_ce      (pixCe),
      .o_hsync       (dHs),
      .o_vsync       (dVs),
      .o_de          (dDe),
      .o_x           (dX),
      .o_y           (dY),
      .o_line_start  (dLs),
      .o_frame_start (dFs)
   );

   vga_timing_gen #(
      .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
      .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (2),
      .HPOL     (1'b1), .VPOL (1'b0)
   ) u_dutSmall (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_en          (en),
      .i_pix_ce      (pixCe),
      .o_hsync       (sHs),
      .o_vsync       (sVs),
      .o_de          (sDe),
      .o_x           (sX),
      .o_y           (sY),
      .o_line_start  (sLs),
      .o_frame_start (sFs)
   );

   // Expected outputs from the tick count since the run began.
   function automatic outs_t decodeModel(int n, bit run, bit ce,
                                         int ha, int hf, int hs, int hb,
                                         int va, int vf, int vs, int vb,
                                         bit hp, bit vp);
      outs_t o;
      int ht = ha + hf + hs + hb;
      int vt = va + vf + vs + vb;
      int xx;
      int yy;
      o.hsync = ~hp; o.vsync = ~vp; o.de = 1'b0;
      o.x = '0; o.y = '0; o.ls = 1'b0; o.fs = 1'b0;
      if (run) begin
         xx = n % ht;
         yy = (n / ht) % vt;
         o.x = 12'(xx);
         o.y = 12'(yy);
         o.hsync = (xx >= ha + hf && xx < ha + hf + hs) ? hp : ~hp;
         o.vsync = (yy >= va + vf && yy < va + vf + vs) ? vp : ~vp;
         o.de = (xx < ha) && (yy < va);
         o.ls = ce && (xx == 0);
         o.fs = ce && (xx == 0) && (yy == 0);
      end
      return o;
   endfunction

   task automatic checkOutput(string name, int actual, int required);
      checkCount++;
      if (actual != required) begin
         errorCount++;
         if (errorCount <= 40)
            $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, actual, required, $time);
      end
   endtask

   task automatic compareOuts(string tag, outs_t act, outs_t exp);
      checkOutput({tag, " hsync"}, act.hsync, exp.hsync);
      checkOutput({tag, " vsync"}, act.vsync, exp.vsync);
      checkOutput({tag, " de"}, act.de, exp.de);
      checkOutput({tag, " x"}, act.x, exp.x);
      checkOutput({tag, " y"}, act.y, exp.y);
      checkOutput({tag, " line_start"}, act.ls, exp.ls);
      checkOutput({tag, " frame_start"}, act.fs, exp.fs);
   endtask

   // Model state advances on the same edge the DUT samples its inputs.
   always @(posedge clk) begin
      rstAtEdge = rst;
      if (rst || !en) begin
         modelRun = 1'b0;
         modelTicks = 0;
      end else begin
         if (modelRun && pixCe) modelTicks = modelTicks + 1;
         modelRun = 1'b1;
      end
   end

   // Per-cycle comparison of both DUTs against the model, mid-cycle.
   always @(negedge clk) begin
      outs_t combD, combS, expD, expS, actD, actS;
      if (compareEnable) begin
         combD = decodeModel(modelTicks, modelRun, pixCe, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
         combS = decodeModel(modelTicks, modelRun, pixCe, 8, 2, 3, 2, 4, 1, 2, 2, 1'b1, 1'b0);
`ifdef VGA_TG_OUTREG_EN
         expD = rstAtEdge ? decodeModel(0, 1'b0, 1'b0, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0) : prevD;
         expS = rstAtEdge ? decodeModel(0, 1'b0, 1'b0, 8, 2, 3, 2, 4, 1, 2, 2, 1'b1, 1'b0) : prevS;
`else
         expD = combD;
         expS = combS;
`endif
         prevD = combD;
         prevS = combS;
         actD = '{dHs, dVs, dDe, dX, dY, dLs, dFs};
         actS = '{sHs, sVs, sDe, sX, sY, sLs, sFs};
         compareOuts("default", actD, expD);
         compareOuts("small", actS, expS);
      end
   end

   task automatic applyStimulus(bit r, bit e, bit c);
      rst = r;
      en = e;
      pixCe = c;
      @(posedge clk);
      #1;
   endtask

   task automatic waitOutputs();
      @(negedge clk);
`ifdef VGA_TG_OUTREG_EN
      @(negedge clk);
`endif
   endtask

   initial begin
      int deCnt, hsLow, hsFirstX, lsCnt, lsSeen, lsFirst, lsSecond;

      prevD = decodeModel(0, 1'b0, 1'b0, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
      prevS = decodeModel(0, 1'b0, 1'b0, 8, 2, 3, 2, 4, 1, 2, 2, 1'b1, 1'b0);

      applyStimulus(1'b1, 1'b0, 1'b1);
      compareEnable = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("reset de", dDe, 0);
      checkOutput("reset hsync", dHs, 1);
      checkOutput("reset small hsync", sHs, 0);

      // First run: one full default line at full pixel rate.
      applyStimulus(1'b0, 1'b1, 1'b1);
      waitOutputs();
      checkOutput("first frame_start", dFs, 1);
      deCnt = 0; hsLow = 0; hsFirstX = -1; lsCnt = 0;
      for (int i = 0; i < 800; i++) begin
         if (i > 0) @(negedge clk);
         if (dDe) deCnt++;
         if (!dHs) begin
            if (hsFirstX < 0) hsFirstX = int'(dX);
            hsLow++;
         end
         if (dLs) lsCnt++;
      end
      checkOutput("de clks per line", deCnt, 640);
      checkOutput("hsync low clks", hsLow, 96);
      checkOutput("hsync start x", hsFirstX, 656);
      checkOutput("line_start per line", lsCnt, 1);
      @(negedge clk);
      checkOutput("line length 800", dLs, 1);
      checkOutput("line wrap x", int'(dX), 0);

      // Random traffic with occasional en drops and reset pulses.
      for (int i = 0; i < 4000; i++) begin
         applyStimulus($urandom_range(999, 0) == 0,
                       $urandom_range(299, 0) != 0,
                       $urandom_range(3, 0) != 0);
      end

      // en dropped mid-frame, then reasserted.
      repeat (50) applyStimulus(1'b0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      waitOutputs();
      checkOutput("en drop de", dDe, 0);
      checkOutput("en drop hsync", dHs, 1);
      checkOutput("en drop vsync", dVs, 1);
      checkOutput("en drop x", int'(dX), 0);
      applyStimulus(1'b0, 1'b1, 1'b1);
      waitOutputs();
      checkOutput("restart frame_start", dFs, 1);
      checkOutput("restart y", int'(dY), 0);

      // Three-clk reset with en held high.
      repeat (40) applyStimulus(1'b0, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b1);
      @(negedge clk);
      checkOutput("rst over en de", dDe, 0);
      checkOutput("rst over en frame_start", dFs, 0);
      applyStimulus(1'b1, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b1);
      waitOutputs();
      checkOutput("post-rst frame_start", dFs, 1);
      checkOutput("post-rst x", int'(dX), 0);

      // Half-rate pixel enable: default line takes 1600 clks.
      lsSeen = 0; lsFirst = 0; lsSecond = 0;
      for (int i = 0; i < 3600 && lsSeen < 2; i++) begin
         applyStimulus(1'b0, 1'b1, (i % 2) == 0);
         @(negedge clk);
         if (dLs) begin
            if (lsSeen == 0) lsFirst = i;
            else lsSecond = i;
            lsSeen++;
         end
      end
      checkOutput("half-rate line_starts seen", lsSeen, 2);
      checkOutput("half-rate line length", lsSecond - lsFirst, 1600);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
